vga_timing_gen: RTL and testbench

Generates 640x480 @ ~60 Hz VGA raster timing from the 100 MHz board clock. Drives `hCount`, `vCount` and `bright` into `vga_bitchange`, and `hSync`/`vSync` to the VGA connector. Emits `line_tick` and `frame_tick` strobes so game-logic stages can update once per line or frame instead of free-running clock dividers. All outputs are registered.

---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters and registered
// sync, visible-window and line/frame strobes.
module vga_timing_gen #(
    parameter int DIV         = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SY  = 10'(H_SYNC);
    localparam logic [9:0] V_SY  = 10'(V_SYNC);
    localparam logic [9:0] H_VS  = 10'(H_VIS_START);
    localparam logic [9:0] H_VE  = 10'(H_VIS_END);
    localparam logic [9:0] V_VS  = 10'(V_VIS_START);
    localparam logic [9:0] V_VE  = 10'(V_VIS_END);

    logic [DW-1:0] r_div;
    logic          r_pixel_en;
    logic [9:0]    r_h;
    logic [9:0]    r_v;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_bright;
    logic          r_line;
    logic          r_frame;

    logic [9:0]    w_h_nxt;
    logic [9:0]    w_v_nxt;
    logic          w_line;
    logic          w_frame;

    // Next raster position; decodes are taken from it so they land
    // on the same edge as the counters.
    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        w_line  = 1'b0;
        w_frame = 1'b0;
        if (r_pixel_en) begin
            if (r_h == H_MAX) begin
                w_h_nxt = 10'd0;
                w_line  = 1'b1;
                if (r_v == V_MAX) begin
                    w_v_nxt = 10'd0;
                    w_frame = 1'b1;
                end else begin
                    w_v_nxt = r_v + 10'd1;
                end
            end else begin
                w_h_nxt = r_h + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_pixel_en <= 1'b0;
            r_h        <= 10'd0;
            r_v        <= 10'd0;
            r_hsync    <= 1'b0;
            r_vsync    <= 1'b0;
            r_bright   <= 1'b0;
            r_line     <= 1'b0;
            r_frame    <= 1'b0;
        end else begin
            r_div      <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
            r_pixel_en <= (r_div == DIV_MAX);
            r_h        <= w_h_nxt;
            r_v        <= w_v_nxt;
            r_hsync    <= !(w_h_nxt < H_SY);
            r_vsync    <= !(w_v_nxt < V_SY);
            r_bright   <= (w_h_nxt >= H_VS) && (w_h_nxt < H_VE) &&
                          (w_v_nxt >= V_VS) && (w_v_nxt < V_VE);
            r_line     <= w_line;
            r_frame    <= w_frame;
        end
    end

    assign pixel_en   = r_pixel_en;
    assign hCount     = r_h;
    assign vCount     = r_v;
    assign hSync      = r_hsync;
    assign vSync      = r_vsync;
    assign bright     = r_bright;
    assign line_tick  = r_line;
    assign frame_tick = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Random run lengths and async reset pulses; three builds compared each
// cycle against a pixel-count model of the raster.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // a: small raster, DIV=4; b: small raster, DIV=1; c: default build
    logic       a_pe, b_pe, c_pe;
    logic [9:0] a_h, b_h, c_h, a_v, b_v, c_v;
    logic       a_hs, b_hs, c_hs, a_vs, b_vs, c_vs;
    logic       a_br, b_br, c_br, a_lt, b_lt, c_lt, a_ft, b_ft, c_ft;

    vga_timing_gen #(
        .DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5),
        .H_VIS_END(17), .V_TOTAL(12), .V_SYNC(2), .V_VIS_START(3),
        .V_VIS_END(10)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .pixel_en(a_pe), .hCount(a_h),
        .vCount(a_v), .hSync(a_hs), .vSync(a_vs), .bright(a_br),
        .line_tick(a_lt), .frame_tick(a_ft)
    );

    vga_timing_gen #(
        .DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5),
        .H_VIS_END(17), .V_TOTAL(12), .V_SYNC(2), .V_VIS_START(3),
        .V_VIS_END(10)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .pixel_en(b_pe), .hCount(b_h),
        .vCount(b_v), .hSync(b_hs), .vSync(b_vs), .bright(b_br),
        .line_tick(b_lt), .frame_tick(b_ft)
    );

    vga_timing_gen u_c (
        .clk(clk), .rst_n(rst_n), .pixel_en(c_pe), .hCount(c_h),
        .vCount(c_v), .hSync(c_hs), .vSync(c_vs), .bright(c_br),
        .line_tick(c_lt), .frame_tick(c_ft)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs n clk edges after reset release. Pixel p is the
    // number of advances so far: edge m advances when pixel_en was set by
    // edge m-1, i.e. (m-1) is a nonzero multiple of div.
    function automatic logic [31:0] model(
        input int n, input int div, input int ht, input int hsy,
        input int hvs, input int hve, input int vt, input int vsy,
        input int vvs, input int vve);
        int p, pp, h, v;
        logic pe, hs, vs, br, lt, ft;
        if (n == 0) return 32'd0;
        pe = (n % div) == 0;
        p  = (n - 1) / div;
        pp = (n >= 2) ? (n - 2) / div : 0;
        h  = p % ht;
        v  = (p / ht) % vt;
        hs = !(h < hsy);
        vs = !(v < vsy);
        br = (h >= hvs) && (h < hve) && (v >= vvs) && (v < vve);
        lt = (p != pp) && (h == 0);
        ft = lt && (v == 0);
        return {6'd0, pe, 10'(h), 10'(v), hs, vs, br, lt, ft};
    endfunction

    function automatic logic [31:0] pack(
        input logic pe, input logic [9:0] h, input logic [9:0] v,
        input logic hs, input logic vs, input logic br,
        input logic lt, input logic ft);
        return {6'd0, pe, h, v, hs, vs, br, lt, ft};
    endfunction

    int n = 0;
    int a_frames = 0;
    int b_frames = 0;
    int a_last = -1;
    int b_last = -1;

    task automatic step_and_check();
        @(posedge clk);
        n++;
        @(negedge clk);
        check("a_vec", pack(a_pe, a_h, a_v, a_hs, a_vs, a_br, a_lt, a_ft),
              model(n, 4, 20, 3, 5, 17, 12, 2, 3, 10));
        check("b_vec", pack(b_pe, b_h, b_v, b_hs, b_vs, b_br, b_lt, b_ft),
              model(n, 1, 20, 3, 5, 17, 12, 2, 3, 10));
        check("c_vec", pack(c_pe, c_h, c_v, c_hs, c_vs, c_br, c_lt, c_ft),
              model(n, 4, 800, 96, 144, 784, 525, 2, 35, 515));
        if (a_ft) begin
            if (a_last >= 0) check("a_period", 32'(n - a_last), 32'd960);
            a_last = n;
            a_frames++;
        end
        if (b_ft) begin
            if (b_last >= 0) check("b_period", 32'(n - b_last), 32'd240);
            b_last = n;
            b_frames++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"},
              pack(a_pe, a_h, a_v, a_hs, a_vs, a_br, a_lt, a_ft), 32'd0);
        check({tag, "_b"},
              pack(b_pe, b_h, b_v, b_hs, b_vs, b_br, b_lt, b_ft), 32'd0);
        check({tag, "_c"},
              pack(c_pe, c_h, c_v, c_hs, c_vs, c_br, c_lt, c_ft), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
        n = 0;
        repeat (4000) step_and_check();
        check("a_frames_seen", 32'(a_frames >= 3), 32'd1);
        check("b_frames_seen", 32'(b_frames >= 10), 32'd1);
        for (int seg = 0; seg < 15; seg++) begin
            // async pulse between edges: outputs clear without a clock
            #1 rst_n = 1'b0;
            #1 check_zero("rst_async");
            #1 rst_n = 1'b1;
            n = 0;
            a_last = -1;
            b_last = -1;
            repeat ($urandom_range(50, 2000)) step_and_check();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
